// File: rtl/sbus_transfer_ctrl.sv
// Moves one holding register onto another over the shared S-bus, arbitrating round-robin between requesters A and B.
// Latency: grant is registered one cycle after the IDLE sample, and each transfer takes 4 cycles (IDLE, DRIVE, LOAD, DONE).
// Backpressure: a requester holds req until its done pulse; the other request waits in IDLE, and a held req counts as a new request.
module sbus_transfer_ctrl #(
    parameter  int NREG = 4,
    localparam int IW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req,
    input  logic [IW-1:0]   src_a,
    input  logic [IW-1:0]   dst_a,
    input  logic [IW-1:0]   src_b,
    input  logic [IW-1:0]   dst_b,
    output logic [1:0]      grant,
    output logic [IW-1:0]   src_sel,
    output logic            src_oe,
    output logic [NREG-1:0] sr,
    output logic [1:0]      done,
    output logic            busy,
    output logic [7:0]      xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index range check: a non-power-of-two NREG leaves codes with no register behind them.
    localparam logic [IW:0] NREG_L = (IW+1)'(NREG);

    state_t        state_q, state_d;
    logic [1:0]    grant_q;
    logic [IW-1:0] src_q, dst_q;
    logic          last_b_q;   // 1 = B was served last, so A wins the next tie
    logic [7:0]    cnt_q;
    logic          win_b;
    logic          src_ok;

    // Next state, arbitration winner, and outputs decoded from state and latched registers only.
    always_comb begin
        state_d = state_q;
        win_b   = 1'b0;
        src_ok  = ({1'b0, src_q} < NREG_L);
        src_oe  = 1'b0;
        sr      = '0;
        done    = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = DRIVE;
                    win_b   = (req == 2'b10) || ((req == 2'b11) && !last_b_q);
                end
            end
            DRIVE: begin
                state_d = LOAD;
                src_oe  = src_ok;
            end
            LOAD: begin
                state_d = DONE;
                src_oe  = src_ok;
                // An out-of-range dst_q matches no bit, so sr stays zero.
                for (int i = 0; i < NREG; i++) begin
                    sr[i] = (dst_q == IW'(i));
                end
            end
            DONE: begin
                state_d = IDLE;
                done    = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, grant/index latches, round-robin pointer and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            src_q    <= '0;
            dst_q    <= '0;
            last_b_q <= 1'b1;
            cnt_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && (req != 2'b00)) begin
                grant_q <= win_b ? 2'b10 : 2'b01;
                src_q   <= win_b ? src_b : src_a;
                dst_q   <= win_b ? dst_b : dst_a;
            end
            // Counter and pointer take their new values as the FSM enters DONE.
            if (state_q == LOAD) begin
                cnt_q    <= cnt_q + 8'd1;
                last_b_q <= grant_q[1];
            end
            if (state_q == DONE) begin
                grant_q <= 2'b00;
            end
        end
    end

    assign grant    = grant_q;
    assign src_sel  = src_q;
    assign busy     = (state_q != IDLE);
    assign xfer_cnt = cnt_q;

endmodule
